imm_decode_stage: RTL
=====================

# imm_decode_stage

Registered, handshaked immediate-decode stage for the decode pipeline of the RISC-V core. It classifies each incoming 32-bit instruction by format and produces the correctly sign-extended XLEN-wide immediate. It also produces the PC-relative target (pc + imm) one cycle later. Optional skid buffering gives full throughput under backpressure. It sits between fetch and register read and is the XLEN-parametrised, pipelined successor to the combinational immediate generator.

## Interface
- XLEN, 32, datapath/PC width; legal values 32 or 64
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register, in_ready = out_ready || !out_valid
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  instruction, passed through
- out_pc  out  XLEN  pc, passed through
- out_imm  out  XLEN  extended immediate
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
- out_fmt  out  3  imm_fmt_e format code
- out_illegal  out  1  unrecognised opcode

## Operation
- Format by opcode inst[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011, 0001111; also 0011011 when XLEN=64
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011; also 0111011 when XLEN=64
  - anything else, including inst[1:0] != 11: ILL
- Immediates, all sign-extended from inst[31] to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}, sign-extended when XLEN=64
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R and ILL: imm = 0
- out_illegal = 1 only for ILL. ILL entries still flow through the stage; exception handling is downstream.
- out_target is always computed. Consumers use it only for B, J and AUIPC.
- Skid FSM (SKID=1), states EMPTY / ONE / FULL; main register drives the outputs, skid holds overflow:
  - EMPTY: accept → ONE
  - ONE: accept with out_ready → ONE; accept without out_ready → FULL (new entry into skid); out_ready without accept → EMPTY
  - FULL: out_ready → skid moves to main → ONE; no input is accepted in FULL
- in_ready = !(state==FULL), driven from a register (no combinational path from out_ready).
- SKID=0: single register; in_ready combinational from out_ready; EMPTY/ONE states only.
- flush: next state EMPTY. An input offered in the flush cycle is dropped, even though in_ready may be high.
- Order is strictly preserved. An entry transfers when valid && ready on a side.

## Timing
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 instruction per cycle when out_ready=1.
- Output data is held stable while out_valid && !out_ready.
- Reset (asynchronous, any state, including mid-transfer):
  - state EMPTY, out_valid 0, in_ready 1
  - out_imm, out_target, out_pc, out_inst 0; out_fmt FMT_R; out_illegal 0
- First accept is possible in the first clock edge after rst deasserts.
- flush together with a downstream handshake: that output transfer completes; everything else is cleared.
- XLEN=64 arithmetic: pc + imm wraps at 2^64. Same wrap rule at 2^32 for XLEN=32.

## Structure
- Package imm_decode_pkg:
  - imm_fmt_e: FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL (3 bits)
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM, OPC_OP_IMM_32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP_32)
  - skid state enum
- Sub-module imm_extract #(XLEN): purely combinational inst → {fmt, imm, illegal}. The stage instantiates it once on the input side, so the stored entries already hold the decoded results.
- The adder sits on the input side; the target is registered with the entry.

## Test plan
- XLEN=32, inst 0xFE000EE3 (beq x0,x0,-4), pc 0x100 → next cycle: fmt B, imm 0xFFFFFFFC, target 0x000000FC.
- XLEN=32, inst 0xFF9FF06F (jal x0,-8), pc 0x0 → imm 0xFFFFFFF8, target 0xFFFFFFF8 (wrap), fmt J.
- XLEN=64, inst 0x800000B7 (lui x1,0x80000) → imm 0xFFFFFFFF80000000, fmt U; inst 0x00000000 → fmt ILL, illegal 1, imm 0.
- SKID=1, out_ready low for 3 cycles, back-to-back inputs A, B, C:
  - A and B accepted; in_ready falls the cycle after B is accepted; C is held upstream
  - out_ready high → A, B, C emerge on consecutive cycles
- FULL state, flush=1 with in_valid=1 → next cycle out_valid 0, in_ready 1, the flushed entries and the input never appear at the output.
- rst pulsed while in FULL with out_ready=0 → out_valid 0 and in_ready 1 immediately, all data outputs 0; normal flow resumes on the first edge after release.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the immediate-decode stage.
//   imm_fmt_e     : instruction format classification (3 bits)
//   OPC_*         : major opcode values, inst[6:0]
//   skid_state_e  : occupancy state of the stage (empty / one entry / two entries)
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
// Classifies a 32-bit instruction by its opcode and produces the immediate
// sign-extended from inst[31] to XLEN bits.
//   inst    in   32    instruction word
//   fmt     out  3     format code (imm_fmt_e)
//   imm     out  XLEN  sign-extended immediate (0 for R and ILL)
//   illegal out  1     opcode not recognised
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam bit Rv64 = (XLEN == 64);

  logic [31:0] imm32;

  // Opcodes with inst[1:0] != 2'b11 never match a listed value, so they land in ILL.
  always_comb begin
    fmt = FMT_ILL;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
      OPC_OP_IMM_32: fmt = Rv64 ? FMT_I : FMT_ILL;
      OPC_STORE:     fmt = FMT_S;
      OPC_BRANCH:    fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:       fmt = FMT_J;
      OPC_OP:        fmt = FMT_R;
      OPC_OP_32:     fmt = Rv64 ? FMT_R : FMT_ILL;
      default:       fmt = FMT_ILL;
    endcase
  end

  // Every format's immediate fits in 32 bits; build it there, then widen.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed cast sign-extends U-type on RV64 as well.
  assign imm     = XLEN'($signed(imm32));
  assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered, handshaked immediate-decode stage.
// Decodes each accepted instruction on the input side (format, immediate,
// pc + imm) and stores the results with the entry. With SKID=1 a second
// entry absorbs backpressure so in_ready can come from a flop; with SKID=0
// a single register is used and in_ready depends combinationally on out_ready.
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous kill of all held entries and the offered input
//   in_valid/in_ready   upstream handshake; in_inst, in_pc payload
//   out_valid/out_ready downstream handshake
//   out_inst, out_pc    passed through
//   out_imm, out_fmt    decoded immediate and format; out_illegal for ILL
//   out_target          out_pc + out_imm, wrapping at 2^XLEN
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output imm_fmt_e        out_fmt,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  // Input-side decode
  imm_fmt_e        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic            dec_illegal;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst   (in_inst),
    .fmt    (dec_fmt),
    .imm    (dec_imm),
    .illegal(dec_illegal)
  );

  assign dec_target = in_pc + dec_imm;

  // Control
  skid_state_e state_q, state_d;
  logic        in_ready_q;
  logic        accept, pop;
  logic        load_main, load_skid, skid_to_main;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = SKID ? in_ready_q : (out_ready || !out_valid);
  // Input offered during flush is dropped even if in_ready is high.
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (accept) begin
          // Without a skid entry, accept in StOne implies the head is leaving.
          if (pop || !SKID) begin
            load_main = 1'b1;
          end else begin
            load_skid = 1'b1;
            state_d   = StFull;
          end
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          skid_to_main = 1'b1;
          state_d      = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  // Entry storage: main drives the outputs, skid holds the overflow entry.
  logic [31:0]     main_inst_q, skid_inst_q;
  logic [XLEN-1:0] main_pc_q, skid_pc_q;
  logic [XLEN-1:0] main_imm_q, skid_imm_q;
  logic [XLEN-1:0] main_target_q, skid_target_q;
  imm_fmt_e        main_fmt_q, skid_fmt_q;
  logic            main_illegal_q, skid_illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_inst_q    <= '0;
      main_pc_q      <= '0;
      main_imm_q     <= '0;
      main_target_q  <= '0;
      main_fmt_q     <= FMT_R;
      main_illegal_q <= 1'b0;
      skid_inst_q    <= '0;
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_target_q  <= '0;
      skid_fmt_q     <= FMT_R;
      skid_illegal_q <= 1'b0;
    end else begin
      if (load_main) begin
        main_inst_q    <= in_inst;
        main_pc_q      <= in_pc;
        main_imm_q     <= dec_imm;
        main_target_q  <= dec_target;
        main_fmt_q     <= dec_fmt;
        main_illegal_q <= dec_illegal;
      end else if (skid_to_main) begin
        main_inst_q    <= skid_inst_q;
        main_pc_q      <= skid_pc_q;
        main_imm_q     <= skid_imm_q;
        main_target_q  <= skid_target_q;
        main_fmt_q     <= skid_fmt_q;
        main_illegal_q <= skid_illegal_q;
      end
      if (load_skid) begin
        skid_inst_q    <= in_inst;
        skid_pc_q      <= in_pc;
        skid_imm_q     <= dec_imm;
        skid_target_q  <= dec_target;
        skid_fmt_q     <= dec_fmt;
        skid_illegal_q <= dec_illegal;
      end
    end
  end

  assign out_inst    = main_inst_q;
  assign out_pc      = main_pc_q;
  assign out_imm     = main_imm_q;
  assign out_target  = main_target_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_illegal_q;

endmodule
